mem_bus_arbiter: RTL and testbench

Two-requester arbiter that shares one memory port between the CPU instruction bus (Iw*) and data bus (Dw*). Each requester holds a request until it receives a one-cycle ready pulse. The arbiter registers the winning request onto the shared port, waits for memory completion, and returns read data to the winner. It sits between the CPU and the single-ported memory/peripheral fabric, so the single-cycle and pipelined cores can run against one memory.

---
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 96 +++++++++
 tb/tb_mem_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester, completion and shared memory port signals of mem_bus_arbiter.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  iIReadEnable, iIWriteEnable;
  logic [3:0]            iIByteEnable;
  logic [ADDR_WIDTH-1:0] iIAddress;
  logic [DATA_WIDTH-1:0] iIWriteData, oIReadData;
  logic                  oIReady;
  logic                  iDReadEnable, iDWriteEnable;
  logic [3:0]            iDByteEnable;
  logic [ADDR_WIDTH-1:0] iDAddress;
  logic [DATA_WIDTH-1:0] iDWriteData, oDReadData;
  logic                  oDReady;
  logic                  oMemReadEnable, oMemWriteEnable;
  logic [3:0]            oMemByteEnable;
  logic [ADDR_WIDTH-1:0] oMemAddress;
  logic [DATA_WIDTH-1:0] oMemWriteData, iMemReadData;
  logic                  iMemReady;
  logic                  oBusError, oOwner;
  modport slave (
    input  iIReadEnable, iIWriteEnable, iIByteEnable, iIAddress, iIWriteData,
    input  iDReadEnable, iDWriteEnable, iDByteEnable, iDAddress, iDWriteData,
    input  iMemReadData, iMemReady,
    output oIReadData, oIReady, oDReadData, oDReady,
    output oMemReadEnable, oMemWriteEnable, oMemByteEnable, oMemAddress, oMemWriteData,
    output oBusError, oOwner
  );
  modport master (
    output iIReadEnable, iIWriteEnable, iIByteEnable, iIAddress, iIWriteData,
    output iDReadEnable, iDWriteEnable, iDByteEnable, iDAddress, iDWriteData,
    output iMemReadData, iMemReady,
    input  oIReadData, oIReady, oDReadData, oDReady,
    input  oMemReadEnable, oMemWriteEnable, oMemByteEnable, oMemAddress, oMemWriteData,
    input  oBusError, oOwner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between instruction and data requesters.
// Round-robin by default; define MEM_ARB_DATA_PRIORITY_EN for fixed data-side priority.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic              iCLK,
  input logic              iRST,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [3:0] {IDLE, GRANT_I, GRANT_D, WAIT_I, WAIT_D, DONE_I, DONE_D, ABORT_I, ABORT_D} state_t;
  state_t                state_q;
  logic                  owner_q, re_q, we_q, irdy_q, drdy_q, err_q;
  logic [3:0]            be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, ird_q, drd_q;
  logic [7:0]            cnt_q;
  logic                  req_i, req_d, grant_d, w_rd, w_wr, wd, tmo;
  logic [3:0]            w_be;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  assign req_i = bus.iIReadEnable | bus.iIWriteEnable;
  assign req_d = bus.iDReadEnable | bus.iDWriteEnable;
`ifdef MEM_ARB_DATA_PRIORITY_EN
  assign grant_d = req_d;
`else
  assign grant_d = req_d & (~req_i | ~owner_q);
`endif
  assign w_rd    = grant_d ? bus.iDReadEnable  : bus.iIReadEnable;
  assign w_wr    = grant_d ? bus.iDWriteEnable : bus.iIWriteEnable;
  assign w_be    = grant_d ? bus.iDByteEnable  : bus.iIByteEnable;
  assign w_addr  = grant_d ? bus.iDAddress     : bus.iIAddress;
  assign w_wdata = grant_d ? bus.iDWriteData   : bus.iIWriteData;
  assign wd      = state_q == WAIT_D;
  // fires in the TIMEOUT-th wait cycle, counting that cycle itself
  assign tmo     = cnt_q == 8'(TIMEOUT - 1);
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ird_q   <= '0;
      drd_q   <= '0;
      irdy_q  <= 1'b0;
      drdy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      irdy_q <= 1'b0;
      drdy_q <= 1'b0;
      case (state_q)
        IDLE: if (req_i | req_d) begin
          state_q <= grant_d ? GRANT_D : GRANT_I;
          owner_q <= grant_d;
          re_q    <= w_rd & ~w_wr;
          we_q    <= w_wr;
          be_q    <= w_be;
          addr_q  <= w_addr;
          wdata_q <= w_wdata;
          cnt_q   <= '0;
        end
        GRANT_I: state_q <= WAIT_I;
        GRANT_D: state_q <= WAIT_D;
        WAIT_I, WAIT_D: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus.iMemReady || tmo) begin
            state_q <= bus.iMemReady ? (wd ? DONE_D : DONE_I) : (wd ? ABORT_D : ABORT_I);
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            irdy_q  <= ~wd;
            drdy_q  <= wd;
            err_q   <= err_q | ~bus.iMemReady;
            if (!wd && (re_q || !bus.iMemReady)) ird_q <= bus.iMemReady ? bus.iMemReadData : '0;
            if (wd && (re_q || !bus.iMemReady)) drd_q <= bus.iMemReady ? bus.iMemReadData : '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.oMemReadEnable  = re_q;
  assign bus.oMemWriteEnable = we_q;
  assign bus.oMemByteEnable  = be_q;
  assign bus.oMemAddress     = addr_q;
  assign bus.oMemWriteData   = wdata_q;
  assign bus.oIReadData      = ird_q;
  assign bus.oDReadData      = drd_q;
  assign bus.oIReady         = irdy_q;
  assign bus.oDReady         = drdy_q;
  assign bus.oBusError       = err_q;
  assign bus.oOwner          = owner_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table plus multi-cycle sequences, completions checked by an ordered scoreboard.
module tb_mem_bus_arbiter;
  typedef struct {
    logic        side;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    int          cyc;
  } vec_t;
  typedef struct {
    logic        side;
    logic [31:0] data;
  } exp_t;
  logic        clk, rst_n;
  int          errors, checks, mem_lat, wcnt, rdy_cnt;
  logic [31:0] prev [2];
  exp_t        sbq [$];
  vec_t        vt [6];
  mem_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(255)) dut (
    .iCLK(clk),
    .iRST(rst_n),
    .bus (bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h00400000) ? 32'h8FA80000 : {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic drive(input logic s, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wdat, input logic [3:0] be);
    if (s) begin
      bus.iDReadEnable = rd; bus.iDWriteEnable = wr; bus.iDAddress = a;
      bus.iDWriteData = wdat; bus.iDByteEnable = be;
    end else begin
      bus.iIReadEnable = rd; bus.iIWriteEnable = wr; bus.iIAddress = a;
      bus.iIWriteData = wdat; bus.iIByteEnable = be;
    end
  endtask
  task automatic clr(input logic s);
    drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask
  always @(negedge clk) begin
    if (bus.oMemReadEnable || bus.oMemWriteEnable) wcnt++;
    else wcnt = 0;
    bus.iMemReady    = (wcnt == mem_lat + 2);
    bus.iMemReadData = bus.iMemReady ? memf(bus.oMemAddress) : 32'hBAD0BAD0;
  end
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.oIReady || bus.oDReady)) begin
      rdy_cnt++;
      if (bus.oIReady && bus.oDReady) chk("both ready", 32'h1, 32'h0);
      if (sbq.size() == 0) chk("unexpected ready", 32'(bus.oDReady), 32'hFFFFFFFF);
      else begin
        e = sbq.pop_front();
        chk("ready side", 32'(bus.oDReady), 32'(e.side));
        chk("read data", bus.oDReady ? bus.oDReadData : bus.oIReadData, e.data);
      end
    end
  end
  task automatic run_vec(input vec_t v);
    logic [31:0] e;
    int          c;
    logic        hit;
    e = v.wr ? prev[v.side] : memf(v.addr);
    if (!v.wr) prev[v.side] = e;
    mem_lat = v.lat;
    drive(v.side, v.rd, v.wr, v.addr, v.wdata, v.be);
    sbq.push_back('{v.side, e});
    c = 0;
    hit = 0;
    while (!hit && c < v.cyc + 10) begin
      @(negedge clk);
      c++;
      if (c == 2) begin
        chk("mem addr", bus.oMemAddress, v.addr);
        chk("mem wdata", bus.oMemWriteData, v.wdata);
        chk("mem be", 32'(bus.oMemByteEnable), 32'(v.be));
        chk("mem we", 32'(bus.oMemWriteEnable), 32'(v.wr));
        chk("mem re", 32'(bus.oMemReadEnable), 32'(v.rd & ~v.wr));
        chk("owner", 32'(bus.oOwner), 32'(v.side));
      end
      hit = v.side ? bus.oDReady : bus.oIReady;
    end
    clr(v.side);
    chk("latency", 32'(c), 32'(v.cyc));
    @(negedge clk);
  endtask
  task automatic wait_any(output logic s);
    int   c;
    logic ok;
    c = 0;
    ok = 0;
    while (!ok && c < 30) begin
      @(negedge clk);
      c++;
      ok = bus.oIReady | bus.oDReady;
    end
    s = bus.oDReady;
    if (!ok) chk("ready timeout", 32'(ok), 32'h1);
  endtask
  task automatic do_reset();
    rst_n = 0;
    clr(0);
    clr(1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    prev[0] = 0;
    prev[1] = 0;
    @(negedge clk);
  endtask
  initial begin
    logic        s, seen;
    logic [31:0] ia, da;
    int          n, c, r0;
    errors = 0; checks = 0; wcnt = 0; rdy_cnt = 0; mem_lat = 0;
    prev[0] = 0; prev[1] = 0;
    bus.iMemReady = 0; bus.iMemReadData = 0;
    rst_n = 0;
    clr(0);
    clr(1);
    vt[0] = '{1'b0, 1'b1, 1'b0, 32'h00400000, 32'h0,        4'hF, 2,   5};
    vt[1] = '{1'b1, 1'b0, 1'b1, 32'h10010004, 32'hDEADBEEF, 4'hF, 0,   3};
    vt[2] = '{1'b1, 1'b1, 1'b0, 32'h10010008, 32'h0,        4'hF, 1,   4};
    vt[3] = '{1'b0, 1'b1, 1'b1, 32'h00400010, 32'h12345678, 4'h3, 3,   6};
    vt[4] = '{1'b1, 1'b1, 1'b0, 32'h1001000C, 32'h0,        4'hF, 254, 257};
    vt[5] = '{1'b0, 1'b1, 1'b0, 32'h00400020, 32'h0,        4'hF, 0,   3};
    repeat (2) @(negedge clk);
    chk("rst oIReady", 32'(bus.oIReady), 32'h0);
    chk("rst oDReady", 32'(bus.oDReady), 32'h0);
    chk("rst mem re", 32'(bus.oMemReadEnable), 32'h0);
    chk("rst mem we", 32'(bus.oMemWriteEnable), 32'h0);
    chk("rst mem addr", bus.oMemAddress, 32'h0);
    chk("rst mem wdata", bus.oMemWriteData, 32'h0);
    chk("rst mem be", 32'(bus.oMemByteEnable), 32'h0);
    chk("rst oIReadData", bus.oIReadData, 32'h0);
    chk("rst oDReadData", bus.oDReadData, 32'h0);
    chk("rst oBusError", 32'(bus.oBusError), 32'h0);
    chk("rst oOwner", 32'(bus.oOwner), 32'h1);
    rst_n = 1;
    @(negedge clk);
    mem_lat = 0;
    drive(0, 1'b1, 1'b0, 32'h00400000, 32'h0, 4'hF);
    drive(1, 1'b0, 1'b1, 32'h10010004, 32'hDEADBEEF, 4'hF);
`ifdef MEM_ARB_DATA_PRIORITY_EN
    sbq.push_back('{1'b1, 32'h0});
    sbq.push_back('{1'b0, 32'h8FA80000});
`else
    sbq.push_back('{1'b0, 32'h8FA80000});
    sbq.push_back('{1'b1, 32'h0});
`endif
    prev[0] = 32'h8FA80000;
    seen = 0;
    n = 0;
    c = 0;
    while (n < 2 && c < 30) begin
      @(negedge clk);
      c++;
      if (bus.oMemWriteEnable && !seen) begin
        seen = 1;
        chk("contested wdata", bus.oMemWriteData, 32'hDEADBEEF);
        chk("contested addr", bus.oMemAddress, 32'h10010004);
      end
      if (bus.oIReady) begin clr(0); n++; end
      if (bus.oDReady) begin clr(1); n++; end
    end
    chk("contested done", 32'(n), 32'h2);
    chk("contested write seen", 32'(seen), 32'h1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_vec(vt[i]);
    chk("no error after boundary", 32'(bus.oBusError), 32'h0);
    do_reset();
    mem_lat = 0;
    ia = 32'h00400100;
    da = 32'h10010100;
    drive(0, 1'b1, 1'b0, ia, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, da, 32'h0, 4'hF);
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_DATA_PRIORITY_EN
      s = 1'b1;
`else
      s = k[0];
`endif
      sbq.push_back('{s, memf(s ? da : ia)});
      wait_any(s);
      if (k == 5) begin
        clr(0);
        clr(1);
      end else if (s) begin
        da = da + 4;
        drive(1, 1'b1, 1'b0, da, 32'h0, 4'hF);
      end else begin
        ia = ia + 4;
        drive(0, 1'b1, 1'b0, ia, 32'h0, 4'hF);
      end
    end
    repeat (2) @(negedge clk);
    mem_lat = 100000;
    drive(1, 1'b1, 1'b0, 32'h10010040, 32'h0, 4'hF);
    sbq.push_back('{1'b1, 32'h0});
    c = 0;
    s = 0;
    while (!s && c < 300) begin
      @(negedge clk);
      c++;
      s = bus.oDReady;
    end
    clr(1);
    chk("abort latency", 32'(c), 32'd257);
    chk("abort error", 32'(bus.oBusError), 32'h1);
    @(negedge clk);
    run_vec('{1'b0, 1'b1, 1'b0, 32'h00400000, 32'h0, 4'hF, 0, 3});
    chk("error sticky", 32'(bus.oBusError), 32'h1);
    chk("owner after I", 32'(bus.oOwner), 32'h0);
    mem_lat = 100000;
    drive(1, 1'b1, 1'b0, 32'h10010080, 32'h0, 4'hF);
    repeat (4) @(negedge clk);
    chk("mid-access re", 32'(bus.oMemReadEnable), 32'h1);
    rst_n = 0;
    #1;
    chk("async rst mem re", 32'(bus.oMemReadEnable), 32'h0);
    chk("async rst mem addr", bus.oMemAddress, 32'h0);
    chk("async rst owner", 32'(bus.oOwner), 32'h1);
    chk("async rst error", 32'(bus.oBusError), 32'h0);
    chk("async rst oIReadData", bus.oIReadData, 32'h0);
    clr(1);
    @(negedge clk);
    rst_n = 1;
    r0 = rdy_cnt;
    repeat (10) @(negedge clk);
    chk("no ready after reset", 32'(rdy_cnt), 32'(r0));
    chk("idle after reset", 32'(bus.oMemReadEnable | bus.oMemWriteEnable), 32'h0);
    chk("scoreboard drained", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
